// File: rtl/pool_window_feeder_if.sv
// pool_window_feeder_if: pixel-in handshake, frame config and window-out bus.
// master drives pixels/config and observes windows; slave is the feeder.
interface pool_window_feeder_if #(
    parameter int BRAM_DATA_WIDTH  = 16,
    parameter int IMAGE_SIZE_WIDTH = 10
);
    logic [BRAM_DATA_WIDTH-1:0]  pix_in_data;
    logic                        pix_in_valid;
    logic                        pix_in_ready;
    logic [IMAGE_SIZE_WIDTH-1:0] image_width;
    logic [IMAGE_SIZE_WIDTH-1:0] image_hight;
    logic [1:0]                  pooling_stride;
    logic [BRAM_DATA_WIDTH-1:0]  bram_data_1;
    logic [BRAM_DATA_WIDTH-1:0]  bram_data_2;
    logic [BRAM_DATA_WIDTH-1:0]  bram_data_3;
    logic [BRAM_DATA_WIDTH-1:0]  bram_data_4;
    logic                        pixel_data_valid;
    logic                        frame_done;

    modport master (
        output pix_in_data,
        output pix_in_valid,
        output image_width,
        output image_hight,
        output pooling_stride,
        input  pix_in_ready,
        input  bram_data_1,
        input  bram_data_2,
        input  bram_data_3,
        input  bram_data_4,
        input  pixel_data_valid,
        input  frame_done
    );

    modport slave (
        input  pix_in_data,
        input  pix_in_valid,
        input  image_width,
        input  image_hight,
        input  pooling_stride,
        output pix_in_ready,
        output bram_data_1,
        output bram_data_2,
        output bram_data_3,
        output bram_data_4,
        output pixel_data_valid,
        output frame_done
    );
endinterface

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: buffers one row-major frame in four parity banks and
// replays it as one pooling window per cycle (TL,TR,BL,BR) on the bus.
// Ports: clk, reset (async active-low), bus (slave modport: pixel
// valid/ready input, W/H/stride config, bram_data_1..4, valid/done pulses).
module pool_window_feeder #(
    parameter int BRAM_DATA_WIDTH  = 16,
    parameter int IMAGE_SIZE_WIDTH = 10,
    parameter int BANK_ADDR_WIDTH  = 12
) (
    input  logic                clk,
    input  logic                reset,
    pool_window_feeder_if.slave bus
);
    localparam int DW    = BRAM_DATA_WIDTH;
    localparam int IW    = IMAGE_SIZE_WIDTH;
    localparam int AW    = BANK_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_done;
    logic [IW-1:0] r_w;
    logic [IW-1:0] r_h;
    logic [1:0]    r_stride;
    logic [AW-1:0] r_half;

    logic [IW-1:0] r_row;
    logic [IW-1:0] r_col;
    logic [AW-1:0] r_wbase;

    logic [IW-1:0] r_ar;
    logic [IW-1:0] r_ac;
    logic [AW-1:0] r_rbase;
    logic          r_issue;
    logic          r_first;
    logic          r_flush;

    logic          r_s1_v;
    logic          r_s1_first;
    logic          r_s1_pr;
    logic          r_s1_pc;
    logic          r_s1_mtr;
    logic          r_s1_mbl;
    logic          r_s1_pass;

    logic          r_pdv;
    logic [DW-1:0] r_q1;
    logic [DW-1:0] r_q2;
    logic [DW-1:0] r_q3;
    logic [DW-1:0] r_q4;

    // ---------------- write side ----------------
    logic          w_idle;
    logic          w_hs;
    logic [IW-1:0] w_cw;
    logic [IW-1:0] w_ch;
    logic [AW-1:0] w_chalf;
    logic [IW-1:0] w_wr_r;
    logic [IW-1:0] w_wr_c;
    logic [AW-1:0] w_wr_base;
    logic [AW-1:0] w_wr_addr;
    logic [1:0]    w_wr_bank;
    logic          w_col_end;
    logic          w_row_end;

    assign w_idle    = (r_state == S_IDLE);
    assign w_hs      = bus.pix_in_valid && r_ready;

    // In IDLE the live config is used for pixel (0,0); later the latched one.
    assign w_cw      = w_idle ? bus.image_width : r_w;
    assign w_ch      = w_idle ? bus.image_hight : r_h;
    assign w_chalf   = AW'(w_cw >> 1);
    assign w_wr_r    = w_idle ? '0 : r_row;
    assign w_wr_c    = w_idle ? '0 : r_col;
    assign w_wr_base = w_idle ? '0 : r_wbase;
    assign w_wr_addr = w_wr_base + AW'(w_wr_c >> 1);
    assign w_wr_bank = {w_wr_r[0], w_wr_c[0]};
    assign w_col_end = (w_wr_c == w_cw - 1'b1);
    assign w_row_end = (w_wr_r == w_ch - 1'b1);

    // ---------------- drain scan ----------------
    logic          w_s2;
    logic [IW-1:0] w_step;
    logic          w_an_row_end;
    logic          w_an_last;
    logic          w_issue;
    logic [IW-1:0] w_ac1;
    logic [IW-1:0] w_ar1;
    logic [AW-1:0] w_base1;

    assign w_s2    = (r_stride == 2'd2);
    assign w_step  = w_s2 ? IW'(2) : IW'(1);
    assign w_an_row_end =
        (r_ac == (w_s2 ? r_w - IW'(2) : r_w - IW'(1)));
    assign w_an_last = w_an_row_end &&
        (r_ar == (w_s2 ? r_h - IW'(2) : r_h - IW'(1)));
    assign w_issue = (r_state == S_DRAIN) && r_issue;
    assign w_ac1   = r_ac + 1'b1;
    assign w_ar1   = r_ar + 1'b1;

    // Bank-row base of anchor row + 1: moves to the next row pair
    // only when the anchor row is odd.
    assign w_base1 = r_ar[0] ? r_rbase + r_half : r_rbase;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_w      <= '0;
            r_h      <= '0;
            r_stride <= '0;
            r_half   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_wbase  <= '0;
            r_ar     <= '0;
            r_ac     <= '0;
            r_rbase  <= '0;
            r_issue  <= 1'b0;
            r_first  <= 1'b0;
            r_flush  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_FILL: begin
                    r_ready <= 1'b1;
                    if (w_hs) begin
                        if (w_idle) begin
                            r_w      <= bus.image_width;
                            r_h      <= bus.image_hight;
                            r_stride <= bus.pooling_stride;
                            r_half   <= w_chalf;
                        end
                        r_state <= S_FILL;
                        if (w_col_end) begin
                            r_col <= '0;
                            r_row <= w_wr_r + 1'b1;
                            r_wbase <= w_wr_r[0] ?
                                w_wr_base + w_chalf : w_wr_base;
                        end else begin
                            r_col   <= w_wr_c + 1'b1;
                            r_row   <= w_wr_r;
                            r_wbase <= w_wr_base;
                        end
                        if (w_col_end && w_row_end) begin
                            r_state <= S_DRAIN;
                            r_ready <= 1'b0;
                            r_ar    <= '0;
                            r_ac    <= '0;
                            r_rbase <= '0;
                            r_issue <= (r_stride != 2'd3);
                            r_first <= 1'b1;
                            r_flush <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_issue) begin
                        r_first <= 1'b0;
                        if (w_an_row_end) begin
                            r_ac <= '0;
                            r_ar <= r_ar + w_step;
                            if (w_s2 || r_ar[0])
                                r_rbase <= r_rbase + r_half;
                            if (w_an_last)
                                r_issue <= 1'b0;
                        end else begin
                            r_ac <= r_ac + w_step;
                        end
                    end else if (r_flush) begin
                        // read + crossbar stages now empty
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- parity banks ----------------
    logic [DW-1:0] w_bq [4];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        localparam bit PR = (b / 2) == 1;
        localparam bit PC = (b % 2) == 1;

        logic [DW-1:0] r_mem [DEPTH];
        logic [DW-1:0] r_q;
        logic [AW-1:0] w_addr;

        // Bank {PR,PC} holds exactly one element of any 2x2 window:
        // row ar or ar+1 and col ac or ac+1, whichever matches parity.
        assign w_addr =
            ((PR != r_ar[0]) ? w_base1 : r_rbase) +
            AW'(((PC != r_ac[0]) ? w_ac1 : r_ac) >> 1);

        always_ff @(posedge clk) begin
            if (w_hs && (w_wr_bank == 2'(b)))
                r_mem[w_wr_addr] <= bus.pix_in_data;
            if (w_issue)
                r_q <= r_mem[w_addr];
        end

        assign w_bq[b] = r_q;
    end

    // ---------------- crossbar ----------------
    logic [1:0]    w_idx;
    logic [DW-1:0] w_tl;
    logic [DW-1:0] w_tr;
    logic [DW-1:0] w_bl;
    logic [DW-1:0] w_br;

    assign w_idx = {r_s1_pr, r_s1_pc};
    assign w_tl  = w_bq[w_idx];
    assign w_tr  = r_s1_pass ? w_tl :
                   r_s1_mtr ? w_bq[w_idx ^ 2'b01] : '0;
    assign w_bl  = r_s1_pass ? w_tl :
                   r_s1_mbl ? w_bq[w_idx ^ 2'b10] : '0;
    assign w_br  = r_s1_pass ? w_tl :
                   (r_s1_mtr && r_s1_mbl) ?
                   w_bq[w_idx ^ 2'b11] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_v     <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_pr    <= 1'b0;
            r_s1_pc    <= 1'b0;
            r_s1_mtr   <= 1'b0;
            r_s1_mbl   <= 1'b0;
            r_s1_pass  <= 1'b0;
            r_pdv      <= 1'b0;
            r_q1       <= '0;
            r_q2       <= '0;
            r_q3       <= '0;
            r_q4       <= '0;
        end else begin
            r_s1_v     <= w_issue;
            r_s1_first <= w_issue && r_first;
            r_s1_pr    <= r_ar[0];
            r_s1_pc    <= r_ac[0];
            r_s1_mtr   <= (w_ac1 != r_w);
            r_s1_mbl   <= (w_ar1 != r_h);
            r_s1_pass  <= (r_stride == 2'd0);
            r_pdv      <= r_s1_v && r_s1_first;
            if (r_s1_v) begin
                r_q1 <= w_tl;
                r_q2 <= w_tr;
                r_q3 <= w_bl;
                r_q4 <= w_br;
            end else begin
                r_q1 <= '0;
                r_q2 <= '0;
                r_q3 <= '0;
                r_q4 <= '0;
            end
        end
    end

    assign bus.pix_in_ready     = r_ready;
    assign bus.frame_done       = r_done;
    assign bus.pixel_data_valid = r_pdv;
    assign bus.bram_data_1      = r_q1;
    assign bus.bram_data_2      = r_q2;
    assign bus.bram_data_3      = r_q3;
    assign bus.bram_data_4      = r_q4;
endmodule

// File: tb/tb_pool_window_feeder.sv
// tb_pool_window_feeder: directed frames through pool_window_feeder,
// checking handshake, window order/content and pulse timing.
module tb_pool_window_feeder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pool_window_feeder_if bus ();

    pool_window_feeder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] cap [64][4];

    int tbl1 [16] = '{0, 1, 4, 5, 2, 3, 6, 7,
                      8, 9, 12, 13, 10, 11, 14, 15};

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] px(int w, int h, int r, int c,
                                       logic [15:0] base);
        if (r < h && c < w)
            return base + 16'(r * w + c);
        return 16'h0;
    endfunction

    function automatic logic [15:0] win(int w, int h, int s,
                                        logic [15:0] base,
                                        int k, int q);
        int r;
        int c;
        if (s == 2) begin
            r = 2 * (k / (w / 2));
            c = 2 * (k % (w / 2));
        end else begin
            r = k / w;
            c = k % w;
        end
        if (s == 0) return px(w, h, r, c, base);
        case (q)
            0:       return px(w, h, r, c, base);
            1:       return px(w, h, r, c + 1, base);
            2:       return px(w, h, r + 1, c, base);
            default: return px(w, h, r + 1, c + 1, base);
        endcase
    endfunction

    task automatic send(input int w, input int h, input int s,
                        input logic [15:0] base, input int npix,
                        input bit gaps);
        int p = 0;
        int cyc = 0;
        bit hs;
        bus.image_width    = 10'(w);
        bus.image_hight    = 10'(h);
        bus.pooling_stride = 2'(s);
        while (p < npix && cyc < 2000) begin
            bus.pix_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.pix_in_data  = base + 16'(p);
            hs = bus.pix_in_valid && bus.pix_in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                p++;
                if (gaps && p == 1) begin
                    bus.image_width    = 10'd6;
                    bus.image_hight    = 10'd8;
                    bus.pooling_stride = 2'd0;
                end
            end
        end
        bus.pix_in_valid = 1'b0;
        if (p < npix) chk("fill_timeout", 32'(p), 32'(npix));
    endtask

    // Called right after the edge that accepted the last pixel (t=0).
    task automatic drain(input int w, input int h, input int s,
                         input logic [15:0] base, input string nm);
        int n;
        logic [15:0] e;
        n = (s == 3) ? 0 : (s == 2) ? (w / 2) * (h / 2) : w * h;
        for (int t = 0; t <= n + 3; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            cap[t][0] = bus.bram_data_1;
            cap[t][1] = bus.bram_data_2;
            cap[t][2] = bus.bram_data_3;
            cap[t][3] = bus.bram_data_4;
            chk($sformatf("%s rdy t%0d", nm, t),
                32'(bus.pix_in_ready), 32'(t == n + 3));
            chk($sformatf("%s pdv t%0d", nm, t),
                32'(bus.pixel_data_valid), 32'(n > 0 && t == 2));
            chk($sformatf("%s done t%0d", nm, t),
                32'(bus.frame_done), 32'(t == n + 2));
            for (int q = 0; q < 4; q++) begin
                e = (t >= 2 && t < n + 2) ?
                    win(w, h, s, base, t - 2, q) : 16'h0;
                chk($sformatf("%s d%0d t%0d", nm, q + 1, t),
                    32'(cap[t][q]), 32'(e));
            end
        end
    endtask

    task automatic chk_win(input string nm, input int t,
                           input int a, input int b,
                           input int c, input int d);
        chk($sformatf("%s tl", nm), 32'(cap[t][0]), 32'(a));
        chk($sformatf("%s tr", nm), 32'(cap[t][1]), 32'(b));
        chk($sformatf("%s bl", nm), 32'(cap[t][2]), 32'(c));
        chk($sformatf("%s br", nm), 32'(cap[t][3]), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b0;
        bus.pix_in_valid   = 1'b0;
        bus.pix_in_data    = '0;
        bus.image_width    = '0;
        bus.image_hight    = '0;
        bus.pooling_stride = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rdy", 32'(bus.pix_in_ready), 0);
        chk("rst pdv", 32'(bus.pixel_data_valid), 0);
        chk("rst done", 32'(bus.frame_done), 0);
        chk("rst d1", 32'(bus.bram_data_1), 0);
        chk("rst d4", 32'(bus.bram_data_4), 0);
        reset = 1'b1;

        // 1: 4x4 stride 2
        send(4, 4, 2, 16'h0, 16, 1'b0);
        drain(4, 4, 2, 16'h0, "s1");
        for (int k = 0; k < 4; k++)
            chk_win($sformatf("s1 tbl w%0d", k), k + 2,
                    tbl1[4*k], tbl1[4*k+1], tbl1[4*k+2], tbl1[4*k+3]);

        // 2: 4x4 stride 0
        send(4, 4, 0, 16'h0, 16, 1'b0);
        drain(4, 4, 0, 16'h0, "s2");

        // 3: 4x4 stride 1
        send(4, 4, 1, 16'h0, 16, 1'b0);
        drain(4, 4, 1, 16'h0, "s3");
        chk_win("s3 a00", 2, 0, 1, 4, 5);
        chk_win("s3 a03", 5, 3, 0, 7, 0);
        chk_win("s3 a30", 14, 12, 13, 0, 0);
        chk_win("s3 a33", 17, 15, 0, 0, 0);

        // 4: random valid gaps, config changes after first pixel
        send(4, 4, 2, 16'h40, 16, 1'b1);
        drain(4, 4, 2, 16'h40, "s4");
        chk_win("s4 w0", 2, 16'h40, 16'h41, 16'h44, 16'h45);

        // 5: reset during pixel 9, then a fresh frame
        send(4, 4, 2, 16'h200, 10, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("s5 rdy", 32'(bus.pix_in_ready), 0);
        chk("s5 pdv", 32'(bus.pixel_data_valid), 0);
        chk("s5 d1", 32'(bus.bram_data_1), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("s5 hold pdv%0d", i),
                32'(bus.pixel_data_valid), 0);
        end
        reset = 1'b1;
        send(4, 4, 2, 16'h300, 16, 1'b0);
        drain(4, 4, 2, 16'h300, "s5b");

        // 6: back-to-back 8x2 stride 2 then 4x4 stride 1
        send(8, 2, 2, 16'h500, 16, 1'b0);
        drain(8, 2, 2, 16'h500, "s6a");
        chk_win("s6a w3", 5, 16'h506, 16'h507, 16'h50e, 16'h50f);
        send(4, 4, 1, 16'h600, 16, 1'b0);
        drain(4, 4, 1, 16'h600, "s6b");

        // stride 3: no windows, frame_done only
        send(2, 2, 3, 16'h700, 4, 1'b0);
        drain(2, 2, 3, 16'h700, "s7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
